// File: rtl/shift_pkg.sv
// Shared encodings for the parametrised universal shift register:
// burst controller states and shift direction constants.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_register_param_if.sv
// Control/data bundle of the universal shift register. The driving controller
// takes the master side and the register takes the slave side.
interface shift_register_param_if #(
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             Ser_In;
  logic [WIDTH-1:0] Par_In;
  logic             Par_load;
  logic             shift_en;
  logic             dir;
  logic             rotate;
  logic             start;
  logic [CNT_W-1:0] shift_cnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Par_out;
  logic             Ser_Out;

  modport master (
    output Ser_In, Par_In, Par_load, shift_en, dir, rotate, start, shift_cnt,
    input  busy, done, Par_out, Ser_Out
  );

  modport slave (
    input  Ser_In, Par_In, Par_load, shift_en, dir, rotate, start, shift_cnt,
    output busy, done, Par_out, Ser_Out
  );
endinterface

// File: rtl/dff.sv
// Single-bit storage cell with asynchronous active-low clear.
module dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= d;
  end

endmodule

// File: rtl/shift_burst_ctrl.sv
// Burst sequencer: decides per cycle whether the datapath loads, shifts or holds,
// and which direction/rotate setting applies (latched during a burst).
module shift_burst_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Par_load,
  input  logic             start,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             rotate,
  input  logic [CNT_W-1:0] shift_cnt,
  output logic             busy,
  output logic             done,
  output logic             load,
  output logic             shift,
  output logic             eff_dir,
  output logic             eff_rot
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic             dir_lat, dir_lat_nxt;
  logic             rot_lat, rot_lat_nxt;
  logic [CNT_W-1:0] cnt_sat;

  assign cnt_sat = (shift_cnt > MAX_CNT) ? MAX_CNT : shift_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      dir_lat   <= 1'b0;
      rot_lat   <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      dir_lat   <= dir_lat_nxt;
      rot_lat   <= rot_lat_nxt;
    end
  end

  // A load always wins; in SHIFT it also abandons the burst without a done pulse.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    dir_lat_nxt   = dir_lat;
    rot_lat_nxt   = rot_lat;
    load          = Par_load;
    shift         = 1'b0;
    case (state)
      IDLE: begin
        if (Par_load) begin
          state_nxt = IDLE;
        end else if (start) begin
          dir_lat_nxt   = dir;
          rot_lat_nxt   = rotate;
          remaining_nxt = cnt_sat;
          state_nxt     = (cnt_sat == '0) ? DONE : SHIFT;
        end else if (shift_en) begin
          shift = 1'b1;
        end
      end
      SHIFT: begin
        if (Par_load) begin
          state_nxt     = IDLE;
          remaining_nxt = '0;
        end else begin
          shift         = 1'b1;
          remaining_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign eff_dir = busy ? dir_lat : dir;
  assign eff_rot = busy ? rot_lat : rotate;

endmodule

// File: rtl/shift_register_param.sv
// Parametrised universal shift register: parallel load, manual or burst shifting
// in either direction, with optional rotate, built from per-bit dff cells.
module shift_register_param
  import shift_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_register_param_if.slave  bus
);

  logic [WIDTH-1:0] q;
  logic             load, shift, eff_dir, eff_rot;
  logic             fill_left, fill_right;

  shift_burst_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .Par_load  (bus.Par_load),
    .start     (bus.start),
    .shift_en  (bus.shift_en),
    .dir       (bus.dir),
    .rotate    (bus.rotate),
    .shift_cnt (bus.shift_cnt),
    .busy      (bus.busy),
    .done      (bus.done),
    .load      (load),
    .shift     (shift),
    .eff_dir   (eff_dir),
    .eff_rot   (eff_rot)
  );

  // Rotating recirculates the bit that falls off the far end.
  assign fill_left  = eff_rot ? q[WIDTH-1] : bus.Ser_In;
  assign fill_right = eff_rot ? q[0]       : bus.Ser_In;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic lower, upper, d;

    if (i == 0) begin : g_lo_edge
      assign lower = fill_left;
    end else begin : g_lo_mid
      assign lower = q[i-1];
    end

    if (i == WIDTH - 1) begin : g_hi_edge
      assign upper = fill_right;
    end else begin : g_hi_mid
      assign upper = q[i+1];
    end

    assign d = load  ? bus.Par_In[i] :
               shift ? ((eff_dir == DIR_RIGHT) ? upper : lower) :
                       q[i];

    dff u_dff (
      .clk (clk),
      .rst (rst),
      .d   (d),
      .q   (q[i])
    );
  end

  assign bus.Par_out = q;
  assign bus.Ser_Out = (eff_dir == DIR_RIGHT) ? q[0] : q[WIDTH-1];

endmodule

// File: tb/tb_shift_register_param.sv
// Directed bench for shift_register_param at WIDTH=8; burst results are
// queued on start and compared by a monitor whenever done is presented.
module tb_shift_register_param;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  shift_register_param_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_register_param #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int               total = 0;
  int               bad   = 0;
  logic [WIDTH-1:0] expQ[$];
  logic [WIDTH-1:0] monExp;
  int               nBusy;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic load, input logic [WIDTH-1:0] par,
                               input logic st, input logic [CNT_W-1:0] cnt,
                               input logic d, input logic rot,
                               input logic sen, input logic ser);
    bus.Par_load  = load;
    bus.Par_In    = par;
    bus.start     = st;
    bus.shift_cnt = cnt;
    bus.dir       = d;
    bus.rotate    = rot;
    bus.shift_en  = sen;
    bus.Ser_In    = ser;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadValue(input logic [WIDTH-1:0] v);
    applyStimulus(1'b1, v, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
  endtask

  // Every done pulse must match one queued burst result, one pulse per entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.done === 1'b1) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedDone: got done=1 expected no pending burst, Par_out=0x%0h",
                 bus.Par_out);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("doneValue", 32'(bus.Par_out), 32'(monExp));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetPar", 32'(bus.Par_out), 32'h00);
    checkOutput("resetBusy", 32'(bus.busy), 32'h0);
    checkOutput("resetDone", 32'(bus.done), 32'h0);
    rst = 1'b1;
    tick();

    // Parallel load then asynchronous clear mid-cycle
    loadValue(8'hA5);
    checkOutput("loadA5", 32'(bus.Par_out), 32'hA5);
    checkOutput("loadBusy", 32'(bus.busy), 32'h0);
    checkOutput("loadDone", 32'(bus.done), 32'h0);
    #2 rst = 1'b0;
    #1 checkOutput("asyncClear", 32'(bus.Par_out), 32'h00);
    tick();
    rst = 1'b1;
    tick();

    // Left burst of 3 with fill 1; live dir flipped after start must not matter
    loadValue(8'h81);
    applyStimulus(1'b0, '0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    expQ.push_back(8'h0F);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("burst3Busy", 32'(bus.busy), 32'h1);
      checkOutput("burst3Done", 32'(bus.done), (k == 3) ? 32'h1 : 32'h0);
      if (k < 3) checkOutput("burst3SerOut", 32'(bus.Ser_Out), (k == 0) ? 32'h1 : 32'h0);
      tick();
    end
    checkOutput("burst3Idle", 32'(bus.busy), 32'h0);
    checkOutput("burst3Par", 32'(bus.Par_out), 32'h0F);

    // Full right rotate restores the value; live rotate cleared after start
    loadValue(8'h81);
    applyStimulus(1'b0, '0, 1'b1, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    expQ.push_back(8'h81);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    countBusy(nBusy);
    checkOutput("rotRightCycles", 32'(nBusy), 32'd9);
    checkOutput("rotRightPar", 32'(bus.Par_out), 32'h81);

    // Oversized count saturates to WIDTH: left rotate, full turn
    applyStimulus(1'b0, '0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
    expQ.push_back(8'h81);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    countBusy(nBusy);
    checkOutput("satCycles", 32'(nBusy), 32'd9);
    checkOutput("satPar", 32'(bus.Par_out), 32'h81);

    // Zero-length burst goes straight to DONE
    applyStimulus(1'b0, '0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    expQ.push_back(8'h81);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("zeroBusy", 32'(bus.busy), 32'h1);
    checkOutput("zeroDone", 32'(bus.done), 32'h1);
    checkOutput("zeroPar", 32'(bus.Par_out), 32'h81);
    tick();
    checkOutput("zeroIdleBusy", 32'(bus.busy), 32'h0);
    checkOutput("zeroIdleDone", 32'(bus.done), 32'h0);

    // Abort a burst of 5 with a load; start/shift_en/dir in SHIFT are ignored
    loadValue(8'h81);
    applyStimulus(1'b0, '0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("abortFirstShift", 32'(bus.Par_out), 32'h02);
    checkOutput("abortBusy", 32'(bus.busy), 32'h1);
    applyStimulus(1'b1, 8'h3C, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abortPar", 32'(bus.Par_out), 32'h3C);
    checkOutput("abortIdle", 32'(bus.busy), 32'h0);
    checkOutput("abortDone", 32'(bus.done), 32'h0);
    repeat (3) tick();
    checkOutput("abortStillIdle", 32'(bus.busy), 32'h0);

    // Manual shifting in IDLE with live direction
    loadValue(8'hF0);
    checkOutput("serOutLeft", 32'(bus.Ser_Out), 32'h1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1 checkOutput("serOutRight", 32'(bus.Ser_Out), 32'h0);
    tick();
    checkOutput("manualShift1", 32'(bus.Par_out), 32'h78);
    tick();
    checkOutput("manualShift2", 32'(bus.Par_out), 32'h3C);
    applyStimulus(1'b1, 8'h99, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("loadBeatsShift", 32'(bus.Par_out), 32'h99);

    // start beats shift_en: no shift on the start edge, then two left shifts of 1
    applyStimulus(1'b0, '0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    expQ.push_back(8'h67);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("startBeatsShift", 32'(bus.Par_out), 32'h99);
    checkOutput("startBusy", 32'(bus.busy), 32'h1);
    countBusy(nBusy);
    checkOutput("burst2Cycles", 32'(nBusy), 32'd3);
    checkOutput("burst2Par", 32'(bus.Par_out), 32'h67);

    tick();
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_register_param.md
Name: shift_register_param

Overview:
- Parametrised universal shift register; successor to the fixed 24/80-bit shift registers.
- Adds configurable width, bidirectional shift, rotate mode, and an autonomous burst mode: shifts N positions on one start command, then signals completion.
- Used by serialiser/deserialiser datapaths that currently sequence shift_en by hand from a controller FSM.

Parameters:
- WIDTH, 24, register width in bits (>=2)
- CNT_W, $clog2(WIDTH+1), width of burst shift count

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- Ser_In  in  1  serial fill bit (ignored when rotating)
- Par_In  in  WIDTH  parallel load data
- Par_load  in  1  parallel load strobe
- shift_en  in  1  manual single-position shift (IDLE only)
- dir  in  1  0 = left (bit i <- bit i-1, fill at bit 0); 1 = right (bit i <- bit i+1, fill at bit WIDTH-1)
- rotate  in  1  1 = fill bit taken from the bit shifted out instead of Ser_In
- start  in  1  begin burst shift
- shift_cnt  in  CNT_W  number of positions for burst (0..WIDTH)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- Par_out  out  WIDTH  register contents
- Ser_Out  out  1  outgoing bit: Par_out[WIDTH-1] if effective dir=0, Par_out[0] if effective dir=1

Behaviour:
- Reset (rst=0, async): register=0, state=IDLE, count=0, busy=0, done=0, latched dir/rotate=0. Takes effect immediately, mid-burst included; a burst interrupted by reset produces no done.
- States: IDLE, SHIFT, DONE.
- IDLE, priority per cycle: Par_load > start > shift_en > hold.
  - Par_load: register <= Par_In next edge.
  - start: latch dir, rotate and shift_cnt. If shift_cnt=0, go to DONE with no shift. Else go to SHIFT with remaining=shift_cnt; no shift on the start edge.
  - shift_en: one shift per cycle using live dir/rotate.
- SHIFT: one shift per cycle using latched dir/rotate; remaining decrements. After the edge where remaining goes 1->0, go to DONE. A burst of N positions takes exactly N cycles in SHIFT.
  - Par_load in SHIFT: aborts the burst. Register <= Par_In, state -> IDLE, no done pulse.
  - start and shift_en ignored in SHIFT.
- DONE: done=1 for exactly one cycle, then IDLE. Par_load in DONE is honoured (load occurs; done still pulses). start in DONE is ignored.
- busy = 1 in SHIFT and DONE, 0 in IDLE.
- Ser_Out is combinational from the register. It uses latched dir when busy, live dir otherwise.
- Rotate: left fill = old bit WIDTH-1; right fill = old bit 0. A burst of WIDTH positions with rotate=1 restores the original value.
- shift_cnt > WIDTH: saturate to WIDTH.
- Outputs driven only from registers plus the Ser_Out mux; no combinational path from start to busy or done.

Decomposition:
- Package shift_pkg: state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and DIR_LEFT/DIR_RIGHT constants.
- Sub-module shift_burst_ctrl: FSM, remaining counter, dir/rotate latches, and busy/done/shift-strobe generation.
- Top level: the WIDTH-bit datapath, built from a generate loop of the existing dff cell with per-bit next-value mux (load / left neighbour / right neighbour / hold).

Test Plan (WIDTH=8):
- Reset, then Par_load with Par_In=8'hA5 -> Par_out=8'hA5 next cycle, busy=0, done=0; assert rst=0 mid-way -> Par_out=8'h00 immediately.
- Load 8'h81; start with shift_cnt=3, dir=0, rotate=0, Ser_In=1 -> busy high for 4 cycles (3 SHIFT + DONE); Par_out=8'h0F; done pulses once in the 4th cycle; Ser_Out sequence before each shift = 1,0,0.
- Load 8'h81; start with shift_cnt=8, dir=1, rotate=1 -> Par_out returns to 8'h81 after 8 shifts; done pulses once.
- start with shift_cnt=0 -> no shift, busy=1 and done=1 in the next cycle, then IDLE.
- Burst of 5 started; Par_load with Par_In=8'h3C asserted in the 2nd SHIFT cycle -> Par_out=8'h3C, state IDLE, done never asserted; start and shift_en during SHIFT have no effect.
- IDLE: manual shift_en for 2 cycles with dir=1, Ser_In=0 on 8'hF0 -> 8'h3C; simultaneous Par_load and shift_en -> load wins.
